// File: rtl/rom_alu_pkg.sv
// Shared constants for the rom_alu datapath slice: width default, runit and rollop codes.
package rom_alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  localparam logic [3:0] RU_IDLE = 4'b0000;
  localparam logic [3:0] RU_ADD  = 4'b1000;
  localparam logic [3:0] RU_AND  = 4'b1001;
  localparam logic [3:0] RU_OR   = 4'b1010;
  localparam logic [3:0] RU_XOR  = 4'b1011;
  localparam logic [3:0] RU_ROLL = 4'b0100;
  localparam logic [3:0] RU_NOT  = 4'b0101;
  localparam logic [3:0] RU_CS1  = 4'b0110;
  localparam logic [3:0] RU_CS2  = 4'b0111;

  localparam logic [2:0] RO_SHL  = 3'b000;
  localparam logic [2:0] RO_SHR  = 3'b001;
  localparam logic [2:0] RO_RCL  = 3'b010;
  localparam logic [2:0] RO_RCR  = 3'b011;
  localparam logic [2:0] RO_ASR  = 3'b100;
  localparam logic [2:0] RO_ROL  = 3'b101;
  localparam logic [2:0] RO_ROR  = 3'b110;
  localparam logic [2:0] RO_PASS = 3'b111;

endpackage

// File: rtl/rom_alu_roll.sv
// Single-bit combinational shifter/rotator for rom_alu; only built with ALU_ROLL_EN defined.
`ifdef ALU_ROLL_EN
module rom_alu_roll
  import rom_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             l_i,
  input  logic [2:0]       rollop_i,
  output logic [WIDTH-1:0] y_o,
  output logic             l_out_o,
  output logic             shift_o
);

  // shift_o is low only for PASS, which leaves L untouched
  always_comb begin
    y_o     = a_i;
    l_out_o = 1'b0;
    shift_o = 1'b1;
    case (rollop_i)
      RO_SHL: begin y_o = {a_i[WIDTH-2:0], 1'b0};       l_out_o = a_i[WIDTH-1]; end
      RO_SHR: begin y_o = {1'b0, a_i[WIDTH-1:1]};       l_out_o = a_i[0];       end
      RO_RCL: begin y_o = {a_i[WIDTH-2:0], l_i};        l_out_o = a_i[WIDTH-1]; end
      RO_RCR: begin y_o = {l_i, a_i[WIDTH-1:1]};        l_out_o = a_i[0];       end
      RO_ASR: begin y_o = {a_i[WIDTH-1], a_i[WIDTH-1:1]}; l_out_o = a_i[0];     end
      RO_ROL: begin y_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]}; l_out_o = a_i[WIDTH-1]; end
      RO_ROR: begin y_o = {a_i[0], a_i[WIDTH-1:1]};     l_out_o = a_i[0];       end
      default: shift_o = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/rom_alu.sv
// CFT 16-bit ALU slice: A/B operand registers, registered result and L-flag controls.
// Optional rotate/shift unit enabled by defining ALU_ROLL_EN; otherwise ROLL acts as PASS.
module rom_alu
  import rom_alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rsthold,
  input  logic [WIDTH-1:0] ibus,
  input  logic             w_a,
  input  logic             w_b,
  input  logic             guard_n,
  input  logic [3:0]       runit,
  input  logic [2:0]       rollop,
  input  logic             l,
  output logic             alu_l_toggle,
  output logic             alu_l_out,
  output logic             alu_l_latch,
  input  logic             ints_n,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned SW = WIDTH + 1;

  logic [WIDTH-1:0] a_q, b_q, y_q, y_d;
  logic             tog_q, tog_d, lout_q, lout_d, latch_q, latch_d;
  logic [SW-1:0]    sum_c, inc_c, dec_c;
  logic [WIDTH-1:0] roll_y_c;
  logic             roll_l_c, roll_shift_c;
  logic             unused_inputs;

`ifdef ALU_ROLL_EN
  rom_alu_roll #(.WIDTH(WIDTH)) u_roll (
    .a_i      (a_q),
    .l_i      (l),
    .rollop_i (rollop),
    .y_o      (roll_y_c),
    .l_out_o  (roll_l_c),
    .shift_o  (roll_shift_c)
  );
  assign unused_inputs = ints_n;
`else
  assign roll_y_c      = a_q;
  assign roll_l_c      = 1'b0;
  assign roll_shift_c  = 1'b0;
  assign unused_inputs = ^{ints_n, guard_n, rollop};
`endif

  assign sum_c = {1'b0, a_q} + {1'b0, b_q};
  assign inc_c = {1'b0, a_q} + SW'(1);
  assign dec_c = {1'b0, a_q} + {1'b0, {WIDTH{1'b1}}};

  // Next result and L controls; everything zero when idle or held
  always_comb begin
    y_d     = '0;
    tog_d   = 1'b0;
    lout_d  = 1'b0;
    latch_d = 1'b0;
    if (rsthold) begin
      case (runit)
        RU_ADD: begin
          y_d    = sum_c[WIDTH-1:0];
          tog_d  = sum_c[WIDTH];
          lout_d = l ^ sum_c[WIDTH];
        end
        RU_AND: y_d = a_q & b_q;
        RU_OR:  y_d = a_q | b_q;
        RU_XOR: y_d = a_q ^ b_q;
        RU_NOT: y_d = ~a_q;
        RU_CS1: begin
          y_d   = inc_c[WIDTH-1:0];
          tog_d = inc_c[WIDTH];
        end
        RU_CS2: begin
          y_d   = dec_c[WIDTH-1:0];
          tog_d = dec_c[WIDTH];
        end
        RU_ROLL: begin
          y_d     = roll_y_c;
          lout_d  = roll_l_c;
          latch_d = roll_shift_c & guard_n;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      tog_q   <= 1'b0;
      lout_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      if (!w_a) a_q <= ibus;
      if (!w_b) b_q <= ibus;
      y_q     <= y_d;
      tog_q   <= tog_d;
      lout_q  <= lout_d;
      latch_q <= latch_d;
    end
  end

  assign y            = y_q;
  assign alu_l_toggle = tog_q;
  assign alu_l_out    = lout_q;
  assign alu_l_latch  = latch_q;

endmodule

// File: tb/tb_rom_alu.sv
// Directed self-checking bench for rom_alu (default build or with ALU_ROLL_EN).
module tb_rom_alu;

  logic        clk = 1'b0;
  logic        reset, rsthold, w_a, w_b, guard_n, l, ints_n;
  logic [15:0] ibus;
  logic [3:0]  runit;
  logic [2:0]  rollop;
  logic        alu_l_toggle, alu_l_out, alu_l_latch;
  logic [15:0] y;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rom_alu dut (
    .clk          (clk),
    .reset        (reset),
    .rsthold      (rsthold),
    .ibus         (ibus),
    .w_a          (w_a),
    .w_b          (w_b),
    .guard_n      (guard_n),
    .runit        (runit),
    .rollop       (rollop),
    .l            (l),
    .alu_l_toggle (alu_l_toggle),
    .alu_l_out    (alu_l_out),
    .alu_l_latch  (alu_l_latch),
    .ints_n       (ints_n),
    .y            (y)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] ey, input logic et,
                     input logic eo, input logic el);
    checks++;
    assert (y === ey && alu_l_toggle === et && alu_l_out === eo && alu_l_latch === el)
    else begin
      failures++;
      $error("FAIL %s: got y=%h tog=%b out=%b latch=%b, want y=%h tog=%b out=%b latch=%b",
             tag, y, alu_l_toggle, alu_l_out, alu_l_latch, ey, et, eo, el);
    end
  endtask

  task automatic chk_yt(input string tag, input logic [15:0] ey, input logic et);
    checks++;
    assert (y === ey && alu_l_toggle === et)
    else begin
      failures++;
      $error("FAIL %s: got y=%h tog=%b, want y=%h tog=%b", tag, y, alu_l_toggle, ey, et);
    end
  endtask

  task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
    runit = 4'b0000;
    ibus = a; w_a = 1'b0; tick(); w_a = 1'b1;
    ibus = b; w_b = 1'b0; tick(); w_b = 1'b1;
  endtask

  task automatic op(input logic [3:0] code);
    runit = code;
    tick();
  endtask

  task automatic roll(input logic [2:0] ro);
    rollop = ro;
    op(4'b0100);
  endtask

  logic [15:0] va, vb;
  logic [16:0] vs;

  initial begin
    reset = 1'b1; rsthold = 1'b1; w_a = 1'b1; w_b = 1'b1; guard_n = 1'b1;
    l = 1'b0; ints_n = 1'b1; ibus = 16'h0; runit = 4'b0000; rollop = 3'b000;
    tick(); tick();
    chk("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    op(4'b0000); chk("idle", 16'h0000, 1'b0, 1'b0, 1'b0);
    op(4'b0101); chk("a_zero_after_reset", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    op(4'b1010); chk("b_zero_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // ADD
    load_ab(16'h5432, 16'hAC00);
    op(4'b1000); chk("add_carry", 16'h0032, 1'b1, 1'b1, 1'b0);
    l = 1'b1; ints_n = 1'b0;
    op(4'b1000); chk("add_carry_l1", 16'h0032, 1'b1, 1'b0, 1'b0);
    l = 1'b0; ints_n = 1'b1;
    load_ab(16'h0003, 16'h0004);
    op(4'b1000); chk("add_small", 16'h0007, 1'b0, 1'b0, 1'b0);
    l = 1'b1;
    op(4'b1000); chk("add_small_l1", 16'h0007, 1'b0, 1'b1, 1'b0);
    l = 1'b0;

    // Load during op uses old A; new A next cycle
    ibus = 16'h0100; w_a = 1'b0;
    op(4'b1000); chk("load_same_cycle_old", 16'h0007, 1'b0, 1'b0, 1'b0);
    w_a = 1'b1;
    op(4'b1000); chk("load_next_cycle_new", 16'h0104, 1'b0, 1'b0, 1'b0);

    load_ab(16'hFFFF, 16'h0001);
    op(4'b1000); chk("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);

    // Logic ops
    load_ab(16'hF0F0, 16'h3C3C);
    op(4'b1001); chk("and", 16'h3030, 1'b0, 1'b0, 1'b0);
    op(4'b1010); chk("or",  16'hFCFC, 1'b0, 1'b0, 1'b0);
    op(4'b1011); chk("xor", 16'hCCCC, 1'b0, 1'b0, 1'b0);
    op(4'b0101); chk("not", 16'h0F0F, 1'b0, 1'b0, 1'b0);
    op(4'b0001); chk("undef_0001", 16'h0000, 1'b0, 1'b0, 1'b0);
    op(4'b1111); chk("undef_1111", 16'h0000, 1'b0, 1'b0, 1'b0);
    op(4'b0000); chk("idle_after_ops", 16'h0000, 1'b0, 1'b0, 1'b0);

    // ROLL
    load_ab(16'h8001, 16'h0000);
    l = 1'b0; guard_n = 1'b1;
`ifdef ALU_ROLL_EN
    roll(3'b000); chk("shl", 16'h0002, 1'b0, 1'b1, 1'b1);
    roll(3'b001); chk("shr", 16'h4000, 1'b0, 1'b1, 1'b1);
    roll(3'b010); chk("rcl_l0", 16'h0002, 1'b0, 1'b1, 1'b1);
    l = 1'b1;
    roll(3'b011); chk("rcr_l1", 16'hC000, 1'b0, 1'b1, 1'b1);
    roll(3'b010); chk("rcl_l1", 16'h0003, 1'b0, 1'b1, 1'b1);
    guard_n = 1'b0;
    roll(3'b011); chk("rcr_guard", 16'hC000, 1'b0, 1'b1, 1'b0);
    guard_n = 1'b1; l = 1'b0;
    roll(3'b100); chk("asr", 16'hC000, 1'b0, 1'b1, 1'b1);
    roll(3'b101); chk("rol", 16'h0003, 1'b0, 1'b1, 1'b1);
    roll(3'b110); chk("ror", 16'hC000, 1'b0, 1'b1, 1'b1);
    roll(3'b111); chk("pass", 16'h8001, 1'b0, 1'b0, 1'b0);
`else
    roll(3'b000); chk("roll_as_pass_shl", 16'h8001, 1'b0, 1'b0, 1'b0);
    l = 1'b1;
    roll(3'b011); chk("roll_as_pass_rcr", 16'h8001, 1'b0, 1'b0, 1'b0);
    guard_n = 1'b0;
    roll(3'b101); chk("roll_as_pass_rol", 16'h8001, 1'b0, 1'b0, 1'b0);
    guard_n = 1'b1; l = 1'b0;
    roll(3'b111); chk("roll_pass", 16'h8001, 1'b0, 1'b0, 1'b0);
`endif

    // Constant steps
    load_ab(16'hFFFF, 16'h0000);
    op(4'b0110); chk_yt("cs1_wrap", 16'h0000, 1'b1);
    load_ab(16'h0000, 16'h0000);
    op(4'b0111); chk_yt("cs2_zero", 16'hFFFF, 1'b0);
    op(4'b0110); chk_yt("cs1_zero", 16'h0001, 1'b0);
    load_ab(16'h0005, 16'h0000);
    op(4'b0111); chk_yt("cs2_five", 16'h0004, 1'b1);

    // ADD sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        va = 16'((i * 32'h5432) % 32'hFFFF);
        vb = 16'((j * 32'h5432) % 32'hFFFF);
        vs = {1'b0, va} + {1'b0, vb};
        l = 1'(i + j);
        load_ab(va, vb);
        op(4'b1000);
        chk("add_sweep", vs[15:0], vs[16], l ^ vs[16], 1'b0);
      end
    end
    l = 1'b0;

    // Reset mid-ADD wins over load and op
    load_ab(16'h1234, 16'h1111);
    op(4'b1000); chk("pre_reset_add", 16'h2345, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; ibus = 16'h7777; w_a = 1'b0; w_b = 1'b0;
    op(4'b1000); chk("reset_mid_add", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; w_a = 1'b1; w_b = 1'b1;
    op(4'b1010); chk("regs_cleared_by_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // rsthold gating
    load_ab(16'hFFFF, 16'h0002);
    op(4'b1000); chk("add_before_hold", 16'h0001, 1'b1, 1'b1, 1'b0);
    rsthold = 1'b0;
    op(4'b1000); chk("hold_zero", 16'h0000, 1'b0, 1'b0, 1'b0);
    op(4'b1000); chk("hold_still_zero", 16'h0000, 1'b0, 1'b0, 1'b0);
    rsthold = 1'b1;
    op(4'b1000); chk("hold_released", 16'h0001, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
